m_decode_stage: RTL and testbench

M_DECODE_STAGE -- requirements
Module: m_decode_stage

---
 rtl/m_decode_stage_if.sv | 39 +++
 rtl/m_decode_stage.sv | 123 ++++++++++++
 tb/tb_m_decode_stage.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/m_decode_stage_if.sv
// Decode-stage bus: instruction offer, register-file read ports, writeback
// snoop, decoded bundle out and the scoreboard view.
interface m_decode_stage_if #(
    parameter int XLEN = 32
);
    typedef struct packed {
        logic [4:0]      rd;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [6:0]      opcode;
        logic [2:0]      funct3;
        logic [6:0]      funct7;
    } s_decoded;

    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [4:0]      rs_sel;
    logic [XLEN-1:0] rs_in;
    logic [4:0]      rq_sel;
    logic [XLEN-1:0] rq_in;
    logic            wb_valid;
    logic [4:0]      wb_sel;
    logic [XLEN-1:0] wb_data;
    logic            out_valid;
    logic            out_ready;
    s_decoded        out_decoded;
    logic [31:0]     busy_mask;

    modport master (
        output in_valid, in_instr, rs_in, rq_in, wb_valid, wb_sel, wb_data, out_ready,
        input  in_ready, rs_sel, rq_sel, out_valid, out_decoded, busy_mask
    );

    modport slave (
        input  in_valid, in_instr, rs_in, rq_in, wb_valid, wb_sel, wb_data, out_ready,
        output in_ready, rs_sel, rq_sel, out_valid, out_decoded, busy_mask
    );
endinterface

// File: rtl/m_decode_stage.sv
// Decode stage: one-deep registered decoded bundle, RAW scoreboard and optional
// writeback-to-decode forwarding. rst_n is released synchronously to clk upstream.
module m_decode_stage #(
    parameter int XLEN   = 32,
    parameter bit FWD_EN = 1'b1
) (
    input logic             clk,
    input logic             rst_n,
    input logic             flush,
    m_decode_stage_if.slave dec
);

    function automatic logic [31:0] reg_bit(input logic [4:0] sel);
        return 32'd1 << sel;
    endfunction

    logic [4:0]      rd_s;
    logic [4:0]      rs_sel_s;
    logic [4:0]      rq_sel_s;
    logic [6:0]      opcode_s;
    logic [2:0]      funct3_s;
    logic [6:0]      funct7_s;

    logic            rs_fwd_s;
    logic            rq_fwd_s;
    logic            hazard_s;
    logic            in_ready_s;
    logic            accept_s;
    logic [XLEN-1:0] a_s;
    logic [XLEN-1:0] b_s;
    logic [31:0]     set_mask_s;
    logic [31:0]     clr_mask_s;

    logic            out_valid_r;
    logic [31:0]     busy_r;
    logic [4:0]      rd_r;
    logic [XLEN-1:0] a_r;
    logic [XLEN-1:0] b_r;
    logic [6:0]      opcode_r;
    logic [2:0]      funct3_r;
    logic [6:0]      funct7_r;

    m_decoder u_decoder (
        .instr  (dec.in_instr),
        .rd     (rd_s),
        .rs_sel (rs_sel_s),
        .rq_sel (rq_sel_s),
        .opcode (opcode_s),
        .funct3 (funct3_s),
        .funct7 (funct7_s)
    );

    // Hazard check, operand select and scoreboard set/clear masks.
    always_comb begin
        rs_fwd_s   = FWD_EN && dec.wb_valid && (dec.wb_sel == rs_sel_s);
        rq_fwd_s   = FWD_EN && dec.wb_valid && (dec.wb_sel == rq_sel_s);
        hazard_s   = (busy_r[rs_sel_s] && !rs_fwd_s) || (busy_r[rq_sel_s] && !rq_fwd_s);
        in_ready_s = !flush && !hazard_s && (!out_valid_r || dec.out_ready);
        accept_s   = dec.in_valid && in_ready_s;
        a_s        = rs_fwd_s ? dec.wb_data : dec.rs_in;
        b_s        = rq_fwd_s ? dec.wb_data : dec.rq_in;
        // r0 is never a real destination, so it is never marked busy.
        set_mask_s = (accept_s && (rd_s != 5'd0)) ? reg_bit(rd_s) : 32'd0;
        clr_mask_s = dec.wb_valid ? reg_bit(dec.wb_sel) : 32'd0;
    end

    // Output bundle register and scoreboard; set is OR-ed after clear so set wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            busy_r      <= 32'd0;
            rd_r        <= 5'd0;
            a_r         <= '0;
            b_r         <= '0;
            opcode_r    <= 7'd0;
            funct3_r    <= 3'd0;
            funct7_r    <= 7'd0;
        end else if (flush) begin
            out_valid_r <= 1'b0;
            busy_r      <= 32'd0;
        end else begin
            busy_r <= (busy_r & ~clr_mask_s) | set_mask_s;
            if (accept_s) begin
                out_valid_r <= 1'b1;
                rd_r        <= rd_s;
                a_r         <= a_s;
                b_r         <= b_s;
                opcode_r    <= opcode_s;
                funct3_r    <= funct3_s;
                funct7_r    <= funct7_s;
            end else if (dec.out_ready) begin
                out_valid_r <= 1'b0;
            end
        end
    end

    assign dec.rs_sel      = rs_sel_s;
    assign dec.rq_sel      = rq_sel_s;
    assign dec.in_ready    = in_ready_s;
    assign dec.out_valid   = out_valid_r;
    assign dec.busy_mask   = busy_r;
    // Concatenation order follows the packed field order of s_decoded.
    assign dec.out_decoded = {rd_r, a_r, b_r, opcode_r, funct3_r, funct7_r};

endmodule

// Pure field extraction of an R-type style instruction word.
module m_decoder (
    input  logic [31:0] instr,
    output logic [4:0]  rd,
    output logic [4:0]  rs_sel,
    output logic [4:0]  rq_sel,
    output logic [6:0]  opcode,
    output logic [2:0]  funct3,
    output logic [6:0]  funct7
);
    assign opcode = instr[6:0];
    assign rd     = instr[11:7];
    assign funct3 = instr[14:12];
    assign rs_sel = instr[19:15];
    assign rq_sel = instr[24:20];
    assign funct7 = instr[31:25];
endmodule

// File: tb/tb_m_decode_stage.sv
// Drives a forwarding and a stalling decode stage with identical stimulus and
// compares both against a per-instance reference model.
module tb_m_decode_stage;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic        t_flush = 1'b0;
    logic        t_in_valid = 1'b0;
    logic [31:0] t_in_instr = 32'd0;
    logic [31:0] t_rs_in = 32'd0;
    logic [31:0] t_rq_in = 32'd0;
    logic        t_wb_valid = 1'b0;
    logic [4:0]  t_wb_sel = 5'd0;
    logic [31:0] t_wb_data = 32'd0;
    logic        t_out_ready = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    m_decode_stage_if #(.XLEN(32)) dif0 ();
    m_decode_stage_if #(.XLEN(32)) dif1 ();

    m_decode_stage #(.XLEN(32), .FWD_EN(1'b1)) u_fwd (
        .clk(clk), .rst_n(rst_n), .flush(t_flush), .dec(dif0.slave));
    m_decode_stage #(.XLEN(32), .FWD_EN(1'b0)) u_stall (
        .clk(clk), .rst_n(rst_n), .flush(t_flush), .dec(dif1.slave));

    assign dif0.in_valid  = t_in_valid;   assign dif1.in_valid  = t_in_valid;
    assign dif0.in_instr  = t_in_instr;   assign dif1.in_instr  = t_in_instr;
    assign dif0.rs_in     = t_rs_in;      assign dif1.rs_in     = t_rs_in;
    assign dif0.rq_in     = t_rq_in;      assign dif1.rq_in     = t_rq_in;
    assign dif0.wb_valid  = t_wb_valid;   assign dif1.wb_valid  = t_wb_valid;
    assign dif0.wb_sel    = t_wb_sel;     assign dif1.wb_sel    = t_wb_sel;
    assign dif0.wb_data   = t_wb_data;    assign dif1.wb_data   = t_wb_data;
    assign dif0.out_ready = t_out_ready;  assign dif1.out_ready = t_out_ready;

    logic [1:0]  o_ready, o_valid;
    logic [31:0] o_busy [2];
    logic [4:0]  o_rs [2], o_rq [2], o_rd [2];
    logic [31:0] o_a [2], o_b [2];
    logic [16:0] o_ctl [2];

    assign o_ready[0] = dif0.in_ready;   assign o_ready[1] = dif1.in_ready;
    assign o_valid[0] = dif0.out_valid;  assign o_valid[1] = dif1.out_valid;
    assign o_busy[0]  = dif0.busy_mask;  assign o_busy[1]  = dif1.busy_mask;
    assign o_rs[0]    = dif0.rs_sel;     assign o_rs[1]    = dif1.rs_sel;
    assign o_rq[0]    = dif0.rq_sel;     assign o_rq[1]    = dif1.rq_sel;
    assign o_rd[0]    = dif0.out_decoded.rd;  assign o_rd[1] = dif1.out_decoded.rd;
    assign o_a[0]     = dif0.out_decoded.a;   assign o_a[1]  = dif1.out_decoded.a;
    assign o_b[0]     = dif0.out_decoded.b;   assign o_b[1]  = dif1.out_decoded.b;
    assign o_ctl[0]   = {dif0.out_decoded.funct7, dif0.out_decoded.funct3, dif0.out_decoded.opcode};
    assign o_ctl[1]   = {dif1.out_decoded.funct7, dif1.out_decoded.funct3, dif1.out_decoded.opcode};

    // Reference model: instance 0 forwards, instance 1 stalls.
    bit          m_busy [2][32];
    bit          m_valid [2];
    logic [4:0]  m_rd [2];
    logic [31:0] m_a [2], m_b [2];
    logic [16:0] m_ctl [2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] r_add(input int rd, input int rs, input int rq);
        return {7'd0, 5'(rq), 5'(rs), 3'd0, 5'(rd), 7'b0110011};
    endfunction

    function automatic logic [31:0] busy_vec(input int k);
        logic [31:0] v;
        for (int i = 0; i < 32; i++) v[i] = m_busy[k][i];
        return v;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_valid[k] = 1'b0;
            m_rd[k]    = 5'd0;
            m_a[k]     = 32'd0;
            m_b[k]     = 32'd0;
            m_ctl[k]   = 17'd0;
            for (int i = 0; i < 32; i++) m_busy[k][i] = 1'b0;
        end
    endtask

    function automatic bit exp_ready(input int k);
        int rs = int'(t_in_instr[19:15]);
        int rq = int'(t_in_instr[24:20]);
        bit fwd_rs = (k == 0) && t_wb_valid && (int'(t_wb_sel) == rs);
        bit fwd_rq = (k == 0) && t_wb_valid && (int'(t_wb_sel) == rq);
        bit haz = (m_busy[k][rs] && !fwd_rs) || (m_busy[k][rq] && !fwd_rq);
        return !t_flush && !haz && (!m_valid[k] || t_out_ready);
    endfunction

    task automatic check_regs();
        for (int k = 0; k < 2; k++) begin
            check($sformatf("out_valid[%0d]", k), {31'd0, o_valid[k]}, {31'd0, m_valid[k]});
            check($sformatf("busy_mask[%0d]", k), o_busy[k], busy_vec(k));
            check($sformatf("rd[%0d]", k), {27'd0, o_rd[k]}, {27'd0, m_rd[k]});
            check($sformatf("a[%0d]", k), o_a[k], m_a[k]);
            check($sformatf("b[%0d]", k), o_b[k], m_b[k]);
            check($sformatf("ctl[%0d]", k), {15'd0, o_ctl[k]}, {15'd0, m_ctl[k]});
        end
    endtask

    // One clock: combinational checks at negedge, model update at posedge, register checks after.
    task automatic step();
        bit rdy [2];
        int rs, rq, rd;
        @(negedge clk);
        rs = int'(t_in_instr[19:15]);
        rq = int'(t_in_instr[24:20]);
        rd = int'(t_in_instr[11:7]);
        for (int k = 0; k < 2; k++) begin
            rdy[k] = exp_ready(k);
            check($sformatf("in_ready[%0d]", k), {31'd0, o_ready[k]}, {31'd0, rdy[k]});
            check($sformatf("rs_sel[%0d]", k), {27'd0, o_rs[k]}, 32'(rs));
            check($sformatf("rq_sel[%0d]", k), {27'd0, o_rq[k]}, 32'(rq));
        end
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                model_reset();
            end else if (t_flush) begin
                m_valid[k] = 1'b0;
                for (int i = 0; i < 32; i++) m_busy[k][i] = 1'b0;
            end else begin
                if (t_wb_valid) m_busy[k][t_wb_sel] = 1'b0;
                if (t_in_valid && rdy[k]) begin
                    if (rd != 0) m_busy[k][rd] = 1'b1;
                    m_valid[k] = 1'b1;
                    m_rd[k]    = 5'(rd);
                    m_a[k] = ((k == 0) && t_wb_valid && int'(t_wb_sel) == rs) ? t_wb_data : t_rs_in;
                    m_b[k] = ((k == 0) && t_wb_valid && int'(t_wb_sel) == rq) ? t_wb_data : t_rq_in;
                    m_ctl[k]   = {t_in_instr[31:25], t_in_instr[14:12], t_in_instr[6:0]};
                end else if (t_out_ready) begin
                    m_valid[k] = 1'b0;
                end
            end
        end
        #1;
        check_regs();
    endtask

    initial begin
        // Reset with an instruction on offer.
        t_in_valid  = 1'b1;
        t_in_instr  = r_add(0, 1, 2);
        t_out_ready = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        model_reset();
        check_regs();
        step();
        step();
        rst_n = 1'b1;
        step();
        for (int k = 0; k < 2; k++) check("rst_release_accept", {31'd0, o_valid[k]}, 32'd1);

        // Latency and backpressure.
        t_in_instr = r_add(5, 1, 2);
        t_rs_in    = 32'haaaaaaaa;
        t_rq_in    = 32'hffffffff;
        step();
        t_out_ready = 1'b0;
        t_in_valid  = 1'b0;
        t_rs_in     = 32'd0;
        t_rq_in     = 32'd0;
        for (int n = 0; n < 3; n++) begin
            step();
            for (int k = 0; k < 2; k++) begin
                check("stall_rd", {27'd0, o_rd[k]}, 32'd5);
                check("stall_a", o_a[k], 32'haaaaaaaa);
                check("stall_b", o_b[k], 32'hffffffff);
                check("stall_busy", o_busy[k], 32'h00000020);
                check("stall_in_ready", {31'd0, o_ready[k]}, 32'd0);
            end
        end

        // RAW hazard: stall without forwarding, same-cycle accept with it.
        t_out_ready = 1'b1;
        t_in_valid  = 1'b1;
        t_in_instr  = r_add(6, 5, 2);
        t_rs_in     = 32'h11111111;
        t_rq_in     = 32'h22222222;
        step();
        for (int k = 0; k < 2; k++) check("raw_blocked", {31'd0, o_ready[k]}, 32'd0);
        t_wb_valid = 1'b1;
        t_wb_sel   = 5'd5;
        t_wb_data  = 32'h12345678;
        #1;
        check("fwd_ready", {31'd0, o_ready[0]}, 32'd1);
        check("nofwd_ready", {31'd0, o_ready[1]}, 32'd0);
        step();
        check("fwd_a", o_a[0], 32'h12345678);
        check("fwd_busy", o_busy[0], 32'h00000040);
        check("nofwd_valid", {31'd0, o_valid[1]}, 32'd0);
        check("nofwd_busy", o_busy[1], 32'd0);
        t_wb_valid = 1'b0;
        step();
        check("nofwd_accept", {31'd0, o_valid[1]}, 32'd1);
        check("nofwd_a", o_a[1], 32'h11111111);
        check("nofwd_busy2", o_busy[1], 32'h00000040);

        // Set wins over same-edge clear.
        t_in_instr = r_add(7, 1, 2);
        step();
        t_wb_valid = 1'b1;
        t_wb_sel   = 5'd7;
        step();
        for (int k = 0; k < 2; k++) check("set_wins", o_busy[k], 32'h000000c0);

        // Flush overrides a pending accept.
        t_in_instr = r_add(5, 1, 2);
        step();
        for (int k = 0; k < 2; k++) check("pre_flush_busy", o_busy[k], 32'h00000060);
        t_wb_valid = 1'b0;
        t_flush    = 1'b1;
        t_in_instr = r_add(9, 1, 2);
        #1;
        for (int k = 0; k < 2; k++) check("flush_ready", {31'd0, o_ready[k]}, 32'd0);
        step();
        for (int k = 0; k < 2; k++) begin
            check("flush_valid", {31'd0, o_valid[k]}, 32'd0);
            check("flush_busy", o_busy[k], 32'd0);
            check("flush_no_accept", {27'd0, o_rd[k]}, 32'd5);
        end
        t_flush = 1'b0;

        // Reset in the middle of a stall discards the held bundle.
        t_in_instr  = r_add(4, 1, 2);
        t_out_ready = 1'b0;
        step();
        step();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_regs();
        step();
        rst_n = 1'b1;

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            t_in_valid  = ($urandom_range(0, 3) != 0);
            t_in_instr  = $urandom;
            t_in_instr[11:7]  = 5'($urandom_range(0, 7));
            t_in_instr[19:15] = 5'($urandom_range(0, 7));
            t_in_instr[24:20] = 5'($urandom_range(0, 7));
            t_rs_in     = $urandom;
            t_rq_in     = $urandom;
            t_wb_valid  = ($urandom_range(0, 2) == 0);
            t_wb_sel    = 5'($urandom_range(0, 7));
            t_wb_data   = $urandom;
            t_out_ready = ($urandom_range(0, 2) != 0);
            t_flush     = ($urandom_range(0, 39) == 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
